// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: an elastic pipeline-stage register that can sit between any
// two CPU stages. It holds one entry in a main register and one in a skid
// register. The skid register lets in_ready depend only on registered state,
// so in_ready never waits on out_ready through combinational logic. Flush
// turns every held entry into a bubble. A saturating counter records how many
// cycles the output was stalled.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic drain;
  logic main_free;
  logic load_main;
  logic load_skid;

  // Derive the handshake terms and pick which register loads this cycle.
  always_comb begin
    accept    = in_valid & in_ready;
    drain     = out_valid & out_ready;
    main_free = ~out_valid | drain;
    load_main = ~flush & main_free & (skid_valid | accept);
    load_skid = ~flush & ~main_free & accept;
  end

  // The stage accepts input while the skid slot is empty. That slot is a
  // flop, so in_ready comes only from registered state.
  assign in_ready = ~skid_valid;

  // Main register valid/control. Control is zeroed on every bubble, so
  // downstream write enables can never fire from stale bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_ctrl  <= skid_ctrl;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end

  // Main register data. It loads only with a real entry and otherwise holds,
  // because bubbles need not clear the wide data field.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data <= '0;
    end else if (load_main) begin
      out_data <= skid_valid ? skid_data : in_data;
    end
  end

  // Skid register valid/control. It fills when an entry is accepted while the
  // main register is stuck, and empties when it moves up into main.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
    end
  end

  // Skid register data. It captures the input only when the skid slot fills.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_data <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
    end
  end

  // Count cycles where a valid output is being held back. The count sticks at
  // its maximum value rather than wrapping. Flush does not affect it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
